// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states,
// the sequential PC step and the default parameter values.
package fetch_pkg;

    // FETCH issues requests; DRAIN swallows responses that belong to a
    // fetch stream abandoned by a redirect.
    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    localparam int unsigned PC_INC = 4;

    localparam int unsigned     DEFAULT_XLEN     = 32;
    localparam logic [63:0]     DEFAULT_RESET_PC = 64'h0;
    localparam int unsigned     DEFAULT_DEPTH    = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs. Flush wins
// over push and pop; the head reads as zero while the FIFO is empty.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointer and occupancy bookkeeping; a push into a full FIFO is only
    // accepted when the head leaves in the same cycle.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty && !flush;
        do_push  = push && (!full || do_pop) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(do_push);
            rd_ptr_d = rd_ptr_q + AW'(do_pop);
            count_d  = count_q + CW'(do_push) - CW'(do_pop);
        end
        count   = count_q;
        rd_data = empty ? '0 : mem_q[rd_ptr_q];
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches under a credit
// limit, buffers in-order responses with their PCs, and handles redirects
// by flushing the buffer and discarding responses still in flight.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int unsigned      DEPTH    = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [XLEN-1:0]  req_addr,
    input  logic             resp_valid,
    input  logic [XLEN-1:0]  resp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [XLEN-1:0]  inst_data,
    output logic [XLEN-1:0]  inst_pc,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc
);

    localparam int          CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_CAP = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(PC_INC - 1);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;
    logic [2*XLEN-1:0] fifo_rd_data;
    logic              fifo_push, fifo_pop;
    logic              req_fire;
    logic [CW:0]       credit_used;

    // Request gating and buffer handshakes; a redirect blocks all of them,
    // and the request is held off while reset is asserted.
    always_comb begin
        credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
        req_valid   = reset_n && (state_q == FETCH) && !redirect_valid
                      && (credit_used < CREDIT_CAP);
        req_addr    = fetch_pc_q;
        req_fire    = req_valid && req_ready;
        fifo_push   = resp_valid && (state_q == FETCH) && !redirect_valid;
        fifo_pop    = !fifo_empty && inst_ready && !redirect_valid;
        inst_valid  = !fifo_empty;
        inst_pc     = fifo_rd_data[2*XLEN-1:XLEN];
        inst_data   = fifo_rd_data[XLEN-1:0];
    end

    // Next-state logic: resp_pc tracks the PC of the next kept response,
    // which after a redirect restarts at the redirect target.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_valid);
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ALIGN_MASK;
            resp_pc_d  = redirect_pc & ALIGN_MASK;
            discard_d  = outstanding_d;
            state_d    = (outstanding_d != '0) ? DRAIN : FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (req_fire) begin
                        fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
                    end
                    if (fifo_push) begin
                        resp_pc_d = resp_pc_q + XLEN'(PC_INC);
                    end
                end
                DRAIN: begin
                    if (resp_valid && (discard_q != '0)) begin
                        discard_d = discard_q - CW'(1);
                    end
                    if (discard_d == '0) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // The credit limit must keep every kept response within buffer space.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(fifo_push && fifo_full && !fifo_pop));
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect_valid),
        .push    (fifo_push),
        .wr_data ({resp_pc_q, resp_data}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with an in-order memory model and a
// second instance that starts near the top of the address space.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        wrap_reset_n = 1'b0;
    logic        w_req_valid;
    logic        w_req_ready = 1'b1;
    logic [31:0] w_req_addr;
    logic        w_resp_valid = 1'b0;
    logic [31:0] w_resp_data = '0;
    logic        w_inst_valid;
    logic        w_inst_ready = 1'b0;
    logic [31:0] w_inst_data;
    logic [31:0] w_inst_pc;
    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc = '0;

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] pend[$];
    bit          mem_auto = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk(clk), .reset_n(wrap_reset_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_addr(w_req_addr),
        .resp_valid(w_resp_valid), .resp_data(w_resp_data),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
        .inst_data(w_inst_data), .inst_pc(w_inst_pc),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // One clock cycle: capture the request handshake, cross the edge, then
    // let the memory answer the oldest pending request if it is enabled.
    task automatic step();
        logic        hs;
        logic [31:0] a;
        #1;
        hs = req_valid && req_ready;
        a  = req_addr;
        @(posedge clk);
        #1;
        if (hs) pend.push_back(a);
        resp_valid = 1'b0;
        resp_data  = '0;
        if (mem_auto && pend.size() > 0) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(pend.pop_front());
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        pend.delete();
        resp_valid     = 1'b0;
        resp_data      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        req_ready      = 1'b1;
        mem_auto       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        inst_ready = 1'b1;
        #3;
        compared++; if (req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req_valid: observed %b, expected 0", req_valid); end
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_inst_valid: observed %b, expected 0", inst_valid); end
        compared++; if (inst_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_inst_data: observed %h, expected 0", inst_data); end
        compared++; if (inst_pc !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_inst_pc: observed %h, expected 0", inst_pc); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        compared++; if (req_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL release_req_valid: observed %b, expected 1", req_valid); end
        compared++; if (req_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL release_req_addr: observed %h, expected 0", req_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        mem_auto   = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp = 32'(4 * i);
            compared++; if (req_valid !== 1'b1 || req_addr !== exp) begin mismatched++; $display("[TB] FAIL stream_req[%0d]: observed %b/%h, expected 1/%h", i, req_valid, req_addr, exp); end
            if (i >= 2) begin
                exp = 32'(4 * (i - 2));
                compared++; if (inst_valid !== 1'b1 || inst_pc !== exp) begin mismatched++; $display("[TB] FAIL stream_inst_pc[%0d]: observed %b/%h, expected 1/%h", i, inst_valid, inst_pc, exp); end
                compared++; if (inst_data !== mem_word(exp)) begin mismatched++; $display("[TB] FAIL stream_inst_data[%0d]: observed %h, expected %h", i, inst_data, mem_word(exp)); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        mem_auto   = 1'b1;
        inst_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_valid && req_ready) begin
                compared++; if (req_addr !== 32'(4 * n)) begin mismatched++; $display("[TB] FAIL bp_req_addr[%0d]: observed %h, expected %h", n, req_addr, 32'(4 * n)); end
                n++;
            end
            step();
        end
        compared++; if (n != 4) begin mismatched++; $display("[TB] FAIL bp_req_count: observed %0d, expected 4", n); end
        compared++; if (req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_req_held: observed %b, expected 0", req_valid); end
        compared++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin mismatched++; $display("[TB] FAIL bp_head_pc: observed %b/%h, expected 1/0", inst_valid, inst_pc); end
        compared++; if (inst_data !== mem_word(32'h0)) begin mismatched++; $display("[TB] FAIL bp_head_data: observed %h, expected %h", inst_data, mem_word(32'h0)); end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        #1;
        compared++; if (req_valid !== 1'b1 || req_addr !== 32'h10) begin mismatched++; $display("[TB] FAIL bp_resume_req: observed %b/%h, expected 1/10", req_valid, req_addr); end
        compared++; if (inst_pc !== 32'h4) begin mismatched++; $display("[TB] FAIL bp_after_pop_pc: observed %h, expected 4", inst_pc); end
    endtask

    task automatic test_redirect();
        int n;
        bit saw_inst;
        do_reset();
        mem_auto   = 1'b0;
        inst_ready = 1'b0;
        repeat (3) step();
        compared++; if (req_valid !== 1'b1 || req_addr !== 32'hC) begin mismatched++; $display("[TB] FAIL redir_pre_req: observed %b/%h, expected 1/c", req_valid, req_addr); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h104;
        #1;
        compared++; if (req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL redir_req_blocked: observed %b, expected 0", req_valid); end
        step();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_auto       = 1'b1;
        #1;
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL redir_inst_valid: observed %b, expected 0", inst_valid); end
        compared++; if (req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL redir_drain_req: observed %b, expected 0", req_valid); end
        n = 0;
        saw_inst = 1'b0;
        while (!req_valid && n < 20) begin
            if (inst_valid) saw_inst = 1'b1;
            step();
            n++;
        end
        compared++; if (n != 4) begin mismatched++; $display("[TB] FAIL redir_drain_cycles: observed %0d, expected 4", n); end
        compared++; if (saw_inst !== 1'b0) begin mismatched++; $display("[TB] FAIL redir_stale_written: observed %b, expected 0", saw_inst); end
        compared++; if (req_addr !== 32'h104) begin mismatched++; $display("[TB] FAIL redir_new_addr: observed %h, expected 104", req_addr); end
        inst_ready = 1'b1;
        n = 0;
        while (!inst_valid && n < 10) begin
            step();
            n++;
        end
        compared++; if (inst_valid !== 1'b1 || inst_pc !== 32'h104) begin mismatched++; $display("[TB] FAIL redir_first_pc: observed %b/%h, expected 1/104", inst_valid, inst_pc); end
        compared++; if (inst_data !== mem_word(32'h104)) begin mismatched++; $display("[TB] FAIL redir_first_data: observed %h, expected %h", inst_data, mem_word(32'h104)); end
    endtask

    task automatic test_redirect_coincident();
        logic [31:0] exp;
        int got;
        do_reset();
        mem_auto   = 1'b1;
        inst_ready = 1'b1;
        repeat (5) step();
        compared++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC) begin mismatched++; $display("[TB] FAIL coin_pre_head: observed %b/%h, expected 1/c", inst_valid, inst_pc); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL coin_flushed: observed %b, expected 0", inst_valid); end
        compared++; if (req_valid !== 1'b1 || req_addr !== 32'h200) begin mismatched++; $display("[TB] FAIL coin_new_req: observed %b/%h, expected 1/200", req_valid, req_addr); end
        exp = 32'h200;
        got = 0;
        for (int i = 0; i < 20 && got < 4; i++) begin
            if (inst_valid && inst_ready) begin
                compared++; if (inst_pc !== exp) begin mismatched++; $display("[TB] FAIL coin_seq_pc[%0d]: observed %h, expected %h", got, inst_pc, exp); end
                exp = exp + 32'h4;
                got++;
            end
            step();
        end
        compared++; if (got != 4) begin mismatched++; $display("[TB] FAIL coin_seq_count: observed %0d, expected 4", got); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hFFFF_FFF8;
        exp_w[1] = 32'hFFFF_FFFC;
        exp_w[2] = 32'h0000_0000;
        wrap_reset_n = 1'b0;
        #3;
        compared++; if (w_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_reset_req: observed %b, expected 0", w_req_valid); end
        @(posedge clk);
        #1;
        wrap_reset_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            compared++; if (w_req_valid !== 1'b1 || w_req_addr !== exp_w[i]) begin mismatched++; $display("[TB] FAIL wrap_addr[%0d]: observed %b/%h, expected 1/%h", i, w_req_valid, w_req_addr, exp_w[i]); end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        mem_auto   = 1'b1;
        inst_ready = 1'b0;
        step();
        mem_auto = 1'b0;
        step();
        step();
        compared++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_pre_head: observed %b/%h, expected 1/0", inst_valid, inst_pc); end
        compared++; if (req_valid !== 1'b1 || req_addr !== 32'hC) begin mismatched++; $display("[TB] FAIL mid_pre_req: observed %b/%h, expected 1/c", req_valid, req_addr); end
        #2;
        reset_n = 1'b0;
        #1;
        compared++; if (req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_req_valid: observed %b, expected 0", req_valid); end
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_inst_valid: observed %b, expected 0", inst_valid); end
        compared++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_inst_zero: observed %h/%h, expected 0/0", inst_data, inst_pc); end
        pend.delete();
        resp_valid = 1'b0;
        resp_data  = '0;
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        mem_auto   = 1'b1;
        inst_ready = 1'b1;
        #1;
        compared++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_restart_req: observed %b/%h, expected 1/0", req_valid, req_addr); end
        step();
        step();
        compared++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_restart_pc: observed %b/%h, expected 1/0", inst_valid, inst_pc); end
        compared++; if (inst_data !== mem_word(32'h0)) begin mismatched++; $display("[TB] FAIL mid_restart_data: observed %h, expected %h", inst_data, mem_word(32'h0)); end
    endtask

    // Runs every scenario in turn and reports the totals.
    initial begin
        $display("[TB] fetch_unit directed bench starting");
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_coincident();
        test_wrap();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guards against a scenario that never finishes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: PC, address and instruction width.
REQ-002 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-003 Parameter DEPTH, default 4, power of two >= 2: instruction buffer entries; also the cap on buffered plus outstanding fetches.
REQ-004 Port clk, input, 1: sole clock, rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port req_valid, output, 1: memory fetch request valid.
REQ-007 Port req_ready, input, 1: memory accepts the request.
REQ-008 Port req_addr, output, XLEN: fetch address, word aligned.
REQ-009 Port resp_valid, input, 1: memory returns one instruction; responses arrive in request order and cannot be stalled.
REQ-010 Port resp_data, input, XLEN: returned instruction.
REQ-011 Port inst_valid, output, 1: buffered instruction available to decode.
REQ-012 Port inst_ready, input, 1: decode consumes the instruction.
REQ-013 Port inst_data, output, XLEN: head instruction.
REQ-014 Port inst_pc, output, XLEN: PC of the head instruction.
REQ-015 Port redirect_valid, input, 1: branch/jump redirect.
REQ-016 Port redirect_pc, input, XLEN: redirect target; bits [1:0] are ignored and treated as 0.

Function
REQ-017 The FSM SHALL have two states: FETCH (requests may issue) and DRAIN (stale responses are discarded, no requests issue).
REQ-018 In FETCH, req_valid SHALL be 1 when (buffer count + outstanding) < DEPTH and redirect_valid=0, with req_addr = fetch_pc.
REQ-019 On req_valid&req_ready, fetch_pc SHALL advance by 4 modulo 2^XLEN, and outstanding SHALL increment.
REQ-020 Each resp_valid SHALL decrement outstanding in the same cycle.
REQ-021 A non-stale response SHALL be written to the buffer together with its PC (issue PC tracked in order); it SHALL be visible on inst_valid/inst_data/inst_pc on the following cycle.
REQ-022 The buffer SHALL never overflow; the credit rule in REQ-018 guarantees this, and an overflow is an assertion failure.
REQ-023 inst_valid SHALL equal "buffer not empty"; the head SHALL pop on inst_valid&inst_ready; push and pop in the same cycle leave the count unchanged.
REQ-024 A redirect in cycle N SHALL cause the following from cycle N+1: buffer empty, inst_valid=0, fetch_pc=redirect_pc, and discard = outstanding remaining after cycle N.
REQ-025 A redirect SHALL take priority over a same-cycle push, pop and request; a same-cycle response is dropped.
REQ-026 After a redirect, the FSM SHALL go to DRAIN if discard>0, else to FETCH.
REQ-027 In DRAIN, each resp_valid SHALL decrement discard without a buffer write; the FSM SHALL return to FETCH in the cycle after discard reaches 0.
REQ-028 A redirect during DRAIN SHALL reload fetch_pc and keep discarding all remaining outstanding responses.
REQ-029 The outstanding and discard counters SHALL each be $clog2(DEPTH)+1 bits wide.

Reset
REQ-030 While reset_n=0: state=FETCH, fetch_pc=RESET_PC, buffer empty, outstanding=0, discard=0, req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-031 The first request SHALL be issued in the first clk edge cycle after reset_n deasserts, with req_addr=RESET_PC.
REQ-032 Asserting reset mid-operation SHALL abandon all in-flight state; the memory side is reset by the same reset_n.

Structure
REQ-033 Package fetch_pkg SHALL hold the FSM state enum, the PC increment constant (4), and the default parameter values.
REQ-034 The buffer SHALL be the sub-module fetch_fifo: a parametrised DEPTH x (2*XLEN) synchronous FIFO with count, full and empty outputs, and a synchronous flush.

Verification
REQ-035 Reset release, req_ready=1, one-cycle memory, inst_ready=1 -> req_addr 0,4,8,...; inst_pc follows 0,4,8 with matching data, with no bubbles after fill.
REQ-036 inst_ready=0 with DEPTH=4 -> exactly 4 requests issue (addresses 0..C); req_valid then stays 0 until a pop.
REQ-037 Redirect to 0x104 with 3 outstanding -> DRAIN; 3 responses dropped; next req_addr=0x104; first inst_pc=0x104.
REQ-038 Redirect coincident with resp_valid and inst_ready -> response dropped, buffer empty next cycle, and no duplicate or lost PC afterwards.
REQ-039 RESET_PC=0xFFFFFFF8, XLEN=32 -> addresses FFFFFFF8, FFFFFFFC, 00000000 (wrap).
REQ-040 reset_n pulsed low mid-stream with 2 outstanding -> all outputs at reset values asynchronously; the fetch restarts at RESET_PC.
